carregador_programa: RTL and testbench

//  Boot loader sitting upstream of MemoriaInstrucoes and the nRisc core. Receives a program as a

---
 rtl/carregador_programa_pkg.sv | 18 +
 rtl/contador_endereco.sv | 44 ++++
 rtl/carregador_programa.sv | 136 +++++++++++++
 tb/tb_carregador_programa.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/carregador_programa_pkg.sv
// Shared definitions for the program boot loader.
//   estado_t       loader FSM states
//   *_PADRAO       default stream / address widths
package carregador_programa_pkg;

    localparam int LARGURA_DADO_PADRAO = 8;
    localparam int LARGURA_END_PADRAO  = 8;

    typedef enum logic [2:0] {
        ESPERA_TAM,
        RECEBE_DADOS,
        RECEBE_CHECKSUM,
        DRENA,
        CONCLUIDO,
        ERRO
    } estado_t;

endpackage

// File: rtl/contador_endereco.sv
// Byte counter for the boot loader: loadable limit, increment, wrapping
// address output and a flag marking the last word of the load.
//   clock, reset   rising-edge clock, synchronous active-high reset
//   carga          clear the count and latch limite_carga as the word total
//   limite_carga   number of words in the load (1 .. 2**LARGURA_END)
//   incrementa     advance the count by one
//   endereco       current word index modulo 2**LARGURA_END
//   ultimo         current word index is the last one of the load
module contador_endereco
    import carregador_programa_pkg::*;
#(
    parameter int LARGURA_END = LARGURA_END_PADRAO
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   carga,
    input  logic [LARGURA_END:0]   limite_carga,
    input  logic                   incrementa,
    output logic [LARGURA_END-1:0] endereco,
    output logic                   ultimo
);

    // One extra bit so a full-capacity load (2**LARGURA_END words) can end.
    logic [LARGURA_END:0] contagem;
    logic [LARGURA_END:0] limite;

    always_ff @(posedge clock) begin
        if (reset) begin
            contagem <= '0;
            limite   <= '0;
        end else if (carga) begin
            contagem <= '0;
            limite   <= limite_carga;
        end else if (incrementa) begin
            contagem <= contagem + 1'b1;
        end
    end

    always_comb begin
        endereco = contagem[LARGURA_END-1:0];
        ultimo   = (contagem == (limite - 1'b1));
    end

endmodule

// File: rtl/carregador_programa.sv
// Boot loader ahead of the instruction memory and the nRisc core. Takes a
// length byte, N program bytes and (optionally) an additive checksum byte
// over a valid/ready stream, writes the program from ENDERECO_BASE and keeps
// the core in reset until the load has completed successfully.
//   Clock, Reset    rising-edge clock, synchronous active-high reset
//   DadoEntrada     stream byte;   EntradaValida / EntradaPronta handshake
//   EndEscrita      registered write address
//   DadoEscrito     registered write data
//   EscInstr        registered one-cycle write strobe
//   ResetCPU        holds the core in reset while high
//   Concluido       load finished with a good checksum
//   ErroChecksum    checksum mismatch, sticky until Reset
module carregador_programa
    import carregador_programa_pkg::*;
#(
    parameter int                     LARGURA_DADO  = LARGURA_DADO_PADRAO,
    parameter int                     LARGURA_END   = LARGURA_END_PADRAO,
    parameter logic [LARGURA_END-1:0] ENDERECO_BASE = '0,
    parameter int                     USA_CHECKSUM  = 1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [LARGURA_DADO-1:0] DadoEntrada,
    input  logic                    EntradaValida,
    output logic                    EntradaPronta,
    output logic [LARGURA_END-1:0]  EndEscrita,
    output logic [LARGURA_DADO-1:0] DadoEscrito,
    output logic                    EscInstr,
    output logic                    ResetCPU,
    output logic                    Concluido,
    output logic                    ErroChecksum
);

    localparam int LARGURA_CONT = LARGURA_END + 1;

    estado_t estado, proximo;

    logic                    aceita;
    logic                    escreve;
    logic                    carga;
    logic                    incrementa;
    logic                    ultimo;
    logic [LARGURA_END-1:0]  endereco;
    logic [LARGURA_END:0]    comprimento;
    logic [LARGURA_END:0]    limite_carga;
    logic [LARGURA_DADO-1:0] soma;

    contador_endereco #(
        .LARGURA_END(LARGURA_END)
    ) u_contador (
        .clock        (Clock),
        .reset        (Reset),
        .carga        (carga),
        .limite_carga (limite_carga),
        .incrementa   (incrementa),
        .endereco     (endereco),
        .ultimo       (ultimo)
    );

    // A length byte of zero means a full-capacity load.
    always_comb begin
        comprimento  = LARGURA_CONT'(DadoEntrada);
        limite_carga = (comprimento == '0) ? {1'b1, {LARGURA_END{1'b0}}} : comprimento;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado <= ESPERA_TAM;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo       = estado;
        EntradaPronta = 1'b0;
        carga         = 1'b0;
        incrementa    = 1'b0;
        escreve       = 1'b0;

        if (!Reset) begin
            EntradaPronta = (estado == ESPERA_TAM) || (estado == RECEBE_DADOS) ||
                            (estado == RECEBE_CHECKSUM);
        end
        aceita = EntradaValida & EntradaPronta;

        case (estado)
            ESPERA_TAM: begin
                if (aceita) begin
                    carga   = 1'b1;
                    proximo = RECEBE_DADOS;
                end
            end
            RECEBE_DADOS: begin
                if (aceita) begin
                    escreve    = 1'b1;
                    incrementa = 1'b1;
                    if (ultimo) begin
                        proximo = (USA_CHECKSUM != 0) ? RECEBE_CHECKSUM : DRENA;
                    end
                end
            end
            RECEBE_CHECKSUM: begin
                if (aceita) begin
                    proximo = (DadoEntrada == soma) ? CONCLUIDO : ERRO;
                end
            end
            // Gives the last registered write a cycle to land before the core is released.
            DRENA:     proximo = CONCLUIDO;
            CONCLUIDO: proximo = CONCLUIDO;
            ERRO:      proximo = ERRO;
            default:   proximo = ESPERA_TAM;
        endcase

        ResetCPU     = Reset | (estado != CONCLUIDO);
        Concluido    = (estado == CONCLUIDO);
        ErroChecksum = (estado == ERRO);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            EndEscrita  <= '0;
            DadoEscrito <= '0;
            EscInstr    <= 1'b0;
            soma        <= '0;
        end else begin
            EscInstr <= escreve;
            if (escreve) begin
                EndEscrita  <= ENDERECO_BASE + endereco;
                DadoEscrito <= DadoEntrada;
                soma        <= soma + DadoEntrada;
            end
        end
    end

endmodule

// File: tb/tb_carregador_programa.sv
// Directed bench for carregador_programa: three instances share one stimulus
// stream (base 00 with checksum, base F0 with checksum, base 00 without).
module tb_carregador_programa;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       valid;

    logic       pronta0, esc0, rcpu0, conc0, erro0;
    logic [7:0] end0, dado0;
    logic       prontaf, escf, rcpuf, concf, errof;
    logic [7:0] endf, dadof;
    logic       prontan, escn, rcpun, concn, erron;
    logic [7:0] endn, dadon;

    int vetores = 0;
    int erros   = 0;

    logic [15:0] wq0[$];
    logic [15:0] wqf[$];
    logic [15:0] wqn[$];
    bit          sobrepoe0 = 1'b0;
    bit          sobrepoen = 1'b0;

    always #5 clk = ~clk;

    carregador_programa #(
        .LARGURA_DADO(8), .LARGURA_END(8), .ENDERECO_BASE(8'h00), .USA_CHECKSUM(1)
    ) dut (
        .Clock(clk), .Reset(rst), .DadoEntrada(din), .EntradaValida(valid),
        .EntradaPronta(pronta0), .EndEscrita(end0), .DadoEscrito(dado0), .EscInstr(esc0),
        .ResetCPU(rcpu0), .Concluido(conc0), .ErroChecksum(erro0)
    );

    carregador_programa #(
        .LARGURA_DADO(8), .LARGURA_END(8), .ENDERECO_BASE(8'hF0), .USA_CHECKSUM(1)
    ) dut_f0 (
        .Clock(clk), .Reset(rst), .DadoEntrada(din), .EntradaValida(valid),
        .EntradaPronta(prontaf), .EndEscrita(endf), .DadoEscrito(dadof), .EscInstr(escf),
        .ResetCPU(rcpuf), .Concluido(concf), .ErroChecksum(errof)
    );

    carregador_programa #(
        .LARGURA_DADO(8), .LARGURA_END(8), .ENDERECO_BASE(8'h00), .USA_CHECKSUM(0)
    ) dut_nc (
        .Clock(clk), .Reset(rst), .DadoEntrada(din), .EntradaValida(valid),
        .EntradaPronta(prontan), .EndEscrita(endn), .DadoEscrito(dadon), .EscInstr(escn),
        .ResetCPU(rcpun), .Concluido(concn), .ErroChecksum(erron)
    );

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (esc0) wq0.push_back({end0, dado0});
        if (escf) wqf.push_back({endf, dadof});
        if (escn) wqn.push_back({endn, dadon});
        if (esc0 && conc0) sobrepoe0 = 1'b1;
        if (escn && concn) sobrepoen = 1'b1;
    end

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        vetores++;
        assert (obs === esp) else begin
            erros++;
            $error("FAIL %s: observed %h expected %h", tag, obs, esp);
        end
    endtask

    task automatic passo();
        @(negedge clk);
        #1;
    endtask

    task automatic ocioso(input int n);
        valid = 1'b0;
        repeat (n) passo();
    endtask

    task automatic envia(input logic [7:0] b);
        logic ok;
        din   = b;
        valid = 1'b1;
        ok    = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            ok = pronta0;
            passo();
        end
        verifica("handshake accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic reinicia();
        rst   = 1'b1;
        valid = 1'b0;
        passo();
        rst = 1'b0;
        wq0.delete();
        wqf.delete();
        wqn.delete();
        sobrepoe0 = 1'b0;
        sobrepoen = 1'b0;
        #1;
    endtask

    initial begin
        int ruins;
        rst   = 1'b1;
        valid = 1'b0;
        din   = 8'h00;
        passo();
        passo();

        // 0: reset values (Reset still high after the reset edge)
        verifica("rst pronta",   {31'd0, pronta0}, 32'd0);
        verifica("rst end",      {24'd0, end0},    32'd0);
        verifica("rst dado",     {24'd0, dado0},   32'd0);
        verifica("rst esc",      {31'd0, esc0},    32'd0);
        verifica("rst resetcpu", {31'd0, rcpu0},   32'd1);
        verifica("rst concl",    {31'd0, conc0},   32'd0);
        verifica("rst erro",     {31'd0, erro0},   32'd0);
        rst = 1'b0;
        #1;
        verifica("pronta after reset", {31'd0, pronta0}, 32'd1);
        verifica("resetcpu while loading", {31'd0, rcpu0}, 32'd1);

        // 1: 03,11,22,33,66 back-to-back
        envia(8'h03);
        envia(8'h11);
        verifica("t1 strobe latency", {31'd0, esc0}, 32'd1);
        verifica("t1 first write", {16'd0, end0, dado0}, 32'h0011);
        envia(8'h22);
        envia(8'h33);
        envia(8'h66);
        ocioso(2);
        verifica("t1 n writes", wq0.size(), 32'd3);
        verifica("t1 w0", {16'd0, wq0[0]}, 32'h0011);
        verifica("t1 w1", {16'd0, wq0[1]}, 32'h0122);
        verifica("t1 w2", {16'd0, wq0[2]}, 32'h0233);
        verifica("t1 concl",    {31'd0, conc0}, 32'd1);
        verifica("t1 resetcpu", {31'd0, rcpu0}, 32'd0);
        verifica("t1 erro",     {31'd0, erro0}, 32'd0);
        verifica("t1 no overlap", {31'd0, sobrepoe0}, 32'd0);

        // 2: bad checksum, then bytes ignored in ERRO
        reinicia();
        envia(8'h02);
        envia(8'hAA);
        envia(8'hBB);
        envia(8'h00);
        ocioso(1);
        verifica("t2 erro",     {31'd0, erro0},   32'd1);
        verifica("t2 concl",    {31'd0, conc0},   32'd0);
        verifica("t2 resetcpu", {31'd0, rcpu0},   32'd1);
        verifica("t2 pronta",   {31'd0, pronta0}, 32'd0);
        din   = 8'h55;
        valid = 1'b1;
        repeat (4) passo();
        valid = 1'b0;
        verifica("t2 n writes", wq0.size(), 32'd2);
        verifica("t2 erro sticky", {31'd0, erro0}, 32'd1);

        // 3: checksum wraps FF+02 -> 01
        reinicia();
        envia(8'h02);
        envia(8'hFF);
        envia(8'h02);
        envia(8'h01);
        ocioso(2);
        verifica("t3 concl", {31'd0, conc0}, 32'd1);
        verifica("t3 n writes", wq0.size(), 32'd2);
        verifica("t3 w0", {16'd0, wq0[0]}, 32'h00FF);
        verifica("t3 w1", {16'd0, wq0[1]}, 32'h0102);

        // 4: length 00 = 256 words, sum 0..255 = 7F80 -> 80
        reinicia();
        envia(8'h00);
        for (int i = 0; i < 256; i++) begin
            envia(8'(i));
        end
        envia(8'h80);
        ocioso(2);
        verifica("t4 n writes", wq0.size(), 32'd256);
        verifica("t4 first", {16'd0, wq0[0]},   32'h0000);
        verifica("t4 last",  {16'd0, wq0[255]}, 32'hFFFF);
        ruins = 0;
        for (int i = 0; i < 256 && i < wq0.size(); i++) begin
            if (wq0[i] !== {8'(i), 8'(i)}) ruins++;
        end
        verifica("t4 contents", ruins, 32'd0);
        verifica("t4 concl", {31'd0, conc0}, 32'd1);
        verifica("t4 no overlap", {31'd0, sobrepoe0}, 32'd0);

        // 5: gaps between bytes, valid held in CONCLUIDO
        reinicia();
        envia(8'h02);
        ocioso(5);
        envia(8'h10);
        ocioso(5);
        envia(8'h20);
        ocioso(5);
        verifica("t5 writes before cks", wq0.size(), 32'd2);
        verifica("t5 not done yet", {31'd0, conc0}, 32'd0);
        envia(8'h30);
        ocioso(2);
        verifica("t5 concl", {31'd0, conc0}, 32'd1);
        verifica("t5 w0", {16'd0, wq0[0]}, 32'h0010);
        verifica("t5 w1", {16'd0, wq0[1]}, 32'h0120);
        din   = 8'h99;
        valid = 1'b1;
        repeat (5) passo();
        valid = 1'b0;
        verifica("t5 no extra writes", wq0.size(), 32'd2);
        verifica("t5 still done", {31'd0, conc0}, 32'd1);

        // 6: reset mid-load on the F0-based instance
        reinicia();
        envia(8'h05);
        envia(8'h01);
        envia(8'h02);
        rst   = 1'b1;
        valid = 1'b0;
        passo();
        verifica("t6 partial writes", wqf.size(), 32'd2);
        verifica("t6 partial w0", {16'd0, wqf[0]}, 32'hF001);
        verifica("t6 rst pronta",   {31'd0, prontaf}, 32'd0);
        verifica("t6 rst end",      {24'd0, endf},    32'd0);
        verifica("t6 rst dado",     {24'd0, dadof},   32'd0);
        verifica("t6 rst esc",      {31'd0, escf},    32'd0);
        verifica("t6 rst resetcpu", {31'd0, rcpuf},   32'd1);
        verifica("t6 rst concl",    {31'd0, concf},   32'd0);
        verifica("t6 rst erro",     {31'd0, errof},   32'd0);
        rst = 1'b0;
        wqf.delete();
        #1;
        envia(8'h01);
        envia(8'h7E);
        envia(8'h7E);
        ocioso(2);
        verifica("t6 n writes", wqf.size(), 32'd1);
        verifica("t6 w0", {16'd0, wqf[0]}, 32'hF07E);
        verifica("t6 concl", {31'd0, concf}, 32'd1);

        // 7: no-checksum instance, DRENA separates last write from Concluido
        reinicia();
        envia(8'h02);
        envia(8'h5A);
        envia(8'hA5);
        valid = 1'b0;
        verifica("t7 last strobe", {31'd0, escn}, 32'd1);
        verifica("t7 last write", {16'd0, endn, dadon}, 32'h01A5);
        verifica("t7 not done with strobe", {31'd0, concn}, 32'd0);
        verifica("t7 pronta in drain", {31'd0, prontan}, 32'd0);
        passo();
        verifica("t7 concl", {31'd0, concn}, 32'd1);
        verifica("t7 resetcpu", {31'd0, rcpun}, 32'd0);
        verifica("t7 erro", {31'd0, erron}, 32'd0);
        verifica("t7 n writes", wqn.size(), 32'd2);
        verifica("t7 w0", {16'd0, wqn[0]}, 32'h005A);
        verifica("t7 no overlap", {31'd0, sobrepoen}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule
